// File: rtl/layer_argmax.sv
// Streaming argmax over one N-node layer: returns index/value of the largest activation per frame.
// Build option ARGMAX_SIGNED_COMPARE_EN selects a full IEEE-754 signed compare instead of raw unsigned.
module layer_argmax #(
   parameter int N  = 15,
   parameter int IW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [31:0]   in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_index,
   output logic [31:0]   out_value,
   output logic          len_err
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] ACC  = 2'b01;
   localparam logic [1:0] HOLD = 2'b10;

   // One extra bit so the element counter can hold N even when N == 2^IW.
   localparam int            CW       = IW + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   logic [1:0]    r_state;
   logic [CW-1:0] r_count;
   logic [31:0]   r_best_value;
   logic [IW-1:0] r_best_index;
   logic          r_len_err;

   logic          w_xfer_in;
   logic          w_xfer_out;
   logic [CW-1:0] w_elem_idx;
   logic          w_is_nth;
   logic          w_frame_end;
   logic          w_len_err;
   logic          w_greater;

   // True when activation a ranks strictly above activation b.
   function automatic logic f_greater(input logic [31:0] a, input logic [31:0] b);
`ifdef ARGMAX_SIGNED_COMPARE_EN
      logic a_nan;
      logic b_nan;
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (a_nan)
         return 1'b0;
      if (b_nan)
         return 1'b1;
      if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
         return 1'b0;
      if (a[31] != b[31])
         return ~a[31];
      if (!a[31])
         return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
`else
      return a > b;
`endif
   endfunction

   // in_ready is gated by rst_n so it reads 0 for the whole reset interval.
   assign in_ready    = rst_n && (r_state != HOLD);
   assign out_valid   = (r_state == HOLD);
   assign out_index   = r_best_index;
   assign out_value   = r_best_value;
   assign len_err     = r_len_err;

   assign w_xfer_in   = in_valid && in_ready;
   assign w_xfer_out  = out_valid && out_ready;
   assign w_elem_idx  = (r_state == ACC) ? r_count : '0;
   assign w_is_nth    = (w_elem_idx == LAST_IDX);
   assign w_frame_end = in_last || w_is_nth;
   // A frame is well-formed only when in_last lands exactly on the Nth element.
   assign w_len_err   = w_is_nth ? ~in_last : 1'b1;
   assign w_greater   = f_greater(in_data, r_best_value);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_count      <= '0;
         r_best_value <= 32'h0000_0000;
         r_best_index <= '0;
         r_len_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_xfer_in) begin
                  r_best_value <= in_data;
                  r_best_index <= '0;
                  r_count      <= CW'(1);
                  if (w_frame_end) begin
                     r_state   <= HOLD;
                     r_len_err <= w_len_err;
                  end else begin
                     r_state   <= ACC;
                  end
               end
            end
            ACC: begin
               if (w_xfer_in) begin
                  if (w_greater) begin
                     r_best_value <= in_data;
                     r_best_index <= w_elem_idx[IW-1:0];
                  end
                  r_count <= r_count + CW'(1);
                  if (w_frame_end) begin
                     r_state   <= HOLD;
                     r_len_err <= w_len_err;
                  end
               end
            end
            HOLD: begin
               if (w_xfer_out) begin
                  r_state <= IDLE;
                  r_count <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_argmax.sv
// Directed bench for layer_argmax: each task drives one scenario and checks expected results inline.
// Build option ARGMAX_SIGNED_COMPARE_EN switches the expectation of the signed-compare scenario.
module tb_layer_argmax;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_index;
   logic [31:0] out_value;
   logic        len_err;

   logic [31:0] vec [0:15];
   int          n_checks = 0;
   int          n_errors = 0;

   layer_argmax #(.N(15), .IW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_value (out_value),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   // Called at posedge+1; sends vec[0..n-1], in_last on element last_at (-1: never).
   task automatic send(input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = vec[i];
         in_last  = (i == last_at);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic fill(input logic [31:0] base);
      for (int i = 0; i < 16; i++) vec[i] = base;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_index, out_value, len_err} !== 39'd0) begin
         n_errors++;
         $display("FAIL reset_state got v=%b r=%b i=%0d val=%h e=%b want all 0",
                  out_valid, in_ready, out_index, out_value, len_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_ready got %b want 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_peak();
      fill(32'h3E80_0000);
      vec[7] = 32'h3F80_0000;
      send(14, -1);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL peak_early_valid got %b want 0", out_valid);
      end
      in_valid = 1'b1; in_data = vec[14]; in_last = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      n_checks++;
      if ({out_valid, out_index, out_value, len_err} !== {1'b1, 4'd7, 32'h3F80_0000, 1'b0}) begin
         n_errors++;
         $display("FAIL peak_result got v=%b i=%0d val=%h e=%b want v=1 i=7 val=3f800000 e=0",
                  out_valid, out_index, out_value, len_err);
      end
      accept();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL peak_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_zeros();
      fill(32'h0000_0000);
      send(15, 14);
      n_checks++;
      if ({out_valid, out_index, out_value, len_err} !== {1'b1, 4'd0, 32'h0, 1'b0}) begin
         n_errors++;
         $display("FAIL zeros_result got v=%b i=%0d val=%h e=%b want v=1 i=0 val=0 e=0",
                  out_valid, out_index, out_value, len_err);
      end
      accept();
   endtask

   task automatic test_tie();
      fill(32'h3E00_0000);
      vec[3] = 32'h3F00_0000;
      vec[9] = 32'h3F00_0000;
      send(15, 14);
      n_checks++;
      if ({out_index, out_value, len_err} !== {4'd3, 32'h3F00_0000, 1'b0}) begin
         n_errors++;
         $display("FAIL tie_result got i=%0d val=%h e=%b want i=3 val=3f000000 e=0",
                  out_index, out_value, len_err);
      end
      accept();
   endtask

   task automatic test_short();
      fill(32'h3F80_0000);
      vec[2] = 32'h4000_0000;
      send(5, 4);
      n_checks++;
      if ({out_valid, out_index, out_value, len_err} !== {1'b1, 4'd2, 32'h4000_0000, 1'b1}) begin
         n_errors++;
         $display("FAIL short_result got v=%b i=%0d val=%h e=%b want v=1 i=2 val=40000000 e=1",
                  out_valid, out_index, out_value, len_err);
      end
      accept();
   endtask

   task automatic test_hold();
      fill(32'h3E80_0000);
      vec[5] = 32'h4040_0000;
      send(15, 14);
      in_valid = 1'b1; in_data = 32'h7F00_0000; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({in_ready, out_valid, out_index, out_value, len_err} !==
             {1'b0, 1'b1, 4'd5, 32'h4040_0000, 1'b0}) begin
            n_errors++;
            $display("FAIL hold_cycle%0d got r=%b v=%b i=%0d val=%h e=%b want r=0 v=1 i=5 val=40400000 e=0",
                     c, in_ready, out_valid, out_index, out_value, len_err);
         end
      end
      accept();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
      in_valid = 1'b0; in_last = 1'b0;
      // Single-element frame straight from IDLE.
      vec[0] = 32'h3DCC_CCCD;
      send(1, 0);
      n_checks++;
      if ({out_valid, out_index, out_value, len_err} !== {1'b1, 4'd0, 32'h3DCC_CCCD, 1'b1}) begin
         n_errors++;
         $display("FAIL single_result got v=%b i=%0d val=%h e=%b want v=1 i=0 val=3dcccccd e=1",
                  out_valid, out_index, out_value, len_err);
      end
      accept();
   endtask

   task automatic test_reset_mid();
      fill(32'h3E80_0000);
      vec[3] = 32'h4100_0000;
      send(6, -1);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready, out_index, out_value, len_err} !== 39'd0) begin
         n_errors++;
         $display("FAIL midreset_state got v=%b r=%b i=%0d val=%h e=%b want all 0",
                  out_valid, in_ready, out_index, out_value, len_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      fill(32'h3F00_0000);
      vec[11] = 32'h3F40_0000;
      send(15, 14);
      n_checks++;
      if ({out_valid, out_index, out_value, len_err} !== {1'b1, 4'd11, 32'h3F40_0000, 1'b0}) begin
         n_errors++;
         $display("FAIL midreset_frame got v=%b i=%0d val=%h e=%b want v=1 i=11 val=3f400000 e=0",
                  out_valid, out_index, out_value, len_err);
      end
      accept();
   endtask

   task automatic test_back_to_back();
      fill(32'h3E80_0000);
      vec[14] = 32'h3F80_0000;
      send(15, -1);
      n_checks++;
      if ({out_valid, out_index, out_value, len_err} !== {1'b1, 4'd14, 32'h3F80_0000, 1'b1}) begin
         n_errors++;
         $display("FAIL cut_result got v=%b i=%0d val=%h e=%b want v=1 i=14 val=3f800000 e=1",
                  out_valid, out_index, out_value, len_err);
      end
      accept();
      fill(32'h3E00_0000);
      vec[1] = 32'h3E40_0000;
      send(3, 2);
      n_checks++;
      if ({out_valid, out_index, out_value, len_err} !== {1'b1, 4'd1, 32'h3E40_0000, 1'b1}) begin
         n_errors++;
         $display("FAIL next_frame got v=%b i=%0d val=%h e=%b want v=1 i=1 val=3e400000 e=1",
                  out_valid, out_index, out_value, len_err);
      end
      accept();
   endtask

   task automatic test_signed();
      logic [3:0]  exp_idx;
      logic [31:0] exp_val;
`ifdef ARGMAX_SIGNED_COMPARE_EN
      exp_idx = 4'd0; exp_val = 32'hBF80_0000;
`else
      exp_idx = 4'd1; exp_val = 32'hC000_0000;
`endif
      vec[0] = 32'hBF80_0000;
      vec[1] = 32'hC000_0000;
      vec[2] = 32'h7FC0_0000;
      send(3, 2);
      n_checks++;
      if ({out_valid, out_index, out_value, len_err} !== {1'b1, exp_idx, exp_val, 1'b1}) begin
         n_errors++;
         $display("FAIL signed_result got v=%b i=%0d val=%h e=%b want v=1 i=%0d val=%h e=1",
                  out_valid, out_index, out_value, len_err, exp_idx, exp_val);
      end
      accept();
   endtask

   initial begin
      test_reset();
      test_peak();
      test_zeros();
      test_tie();
      test_short();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_signed();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/layer_argmax.md
LAYER_ARGMAX -- requirements
Module: layer_argmax

Interface
REQ-001 SHALL have parameter N, default 15, giving the number of activations per frame.
REQ-002 SHALL have parameter IW, default 4, giving the index width, with 2^IW >= N.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the in_data activation is valid.
REQ-006 SHALL have port in_data, input, 32 bits: IEEE-754 single activation from one N-node layer, presented serially in node order 0..N-1.
REQ-007 SHALL have port in_last, input, 1 bit: marks the final activation of a frame.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept an activation.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_index, output, IW bits: node index of the maximum activation.
REQ-012 SHALL have port out_value, output, 32 bits: the maximum activation.
REQ-013 SHALL have port len_err, output, 1 bit: the frame length was not N; qualified by out_valid.

Function
REQ-014 SHALL transfer an input only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL transfer a result only on a cycle where out_valid and out_ready are both 1.
REQ-016 SHALL implement three states: IDLE, ACC and HOLD.
REQ-017 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in HOLD.
REQ-018 SHALL drive out_valid=1 only in HOLD.
REQ-019 SHALL, on a transfer in IDLE: load best_value=in_data, best_index=0, count=1, then go to ACC.
REQ-020 SHALL, on a transfer in ACC: replace best_value/best_index with in_data/count only when in_data is strictly greater than best_value, then increment count.
REQ-021 SHALL resolve ties to the earliest (lowest) index.
REQ-022 SHALL end the frame on the transfer that carries in_last=1 or that is the Nth element, whichever comes first, and enter HOLD on the next edge.
REQ-023 SHALL therefore assert out_valid exactly one cycle after the final input transfer.
REQ-024 SHALL process a frame with a single element (in_last on the first transfer) via IDLE -> HOLD directly, giving out_index=0.
REQ-025 SHALL set len_err=1 when the frame ends with in_last=1 and count<N, or when the Nth element carries in_last=0; otherwise len_err=0.
REQ-026 SHALL, when the frame is cut at N elements with in_last=0, treat the next transfer as element 0 of a new frame.
REQ-027 SHALL hold out_index, out_value and len_err stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, on a result transfer, go to IDLE with out_valid=0 on the next cycle; no input transfer is accepted in that same cycle.
REQ-029 SHALL ignore in_valid, in_data and in_last while in_ready=0.
REQ-030 SHALL not wrap count past N-1; the frame always terminates at N elements.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE, count=0, out_valid=0, in_ready=0, out_index=0, out_value=32'h0000_0000 and len_err=0, independent of clk.
REQ-032 SHALL, on reset assertion mid-frame or in HOLD, discard the partial frame or pending result.
REQ-033 SHALL drive in_ready=1 on the first cycle after rst_n deasserts.

Configuration
REQ-034 SHALL, when macro ARGMAX_SIGNED_COMPARE_EN is defined, use a full IEEE-754 signed compare: positive beats negative; for two negatives the smaller raw magnitude is greater; +0 equals -0; a NaN input never replaces best_value.
REQ-035 SHALL, when ARGMAX_SIGNED_COMPARE_EN is undefined, compare raw in_data as a 32-bit unsigned integer; this is valid for the non-negative ReLU outputs (negatives already clamped to 0) produced by the upstream node stage.

Verification
REQ-036 SHALL cover: 15 elements with 0x3F800000 (1.0) at index 7 and all others 0x3E800000 (0.25), in_last on element 14 -> out_index=7, out_value=0x3F800000, len_err=0, out_valid asserted 1 cycle after the last transfer.
REQ-037 SHALL cover: all 15 elements equal to 0x00000000 -> out_index=0, out_value=0.
REQ-038 SHALL cover: in_last on element 4 with maximum 0x40000000 at index 2 -> out_index=2, len_err=1.
REQ-039 SHALL cover: result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> IDLE next cycle.
REQ-040 SHALL cover: rst_n pulsed low after 6 accepted elements -> outputs at reset values immediately; a following full frame produces a correct, independent result.
REQ-041 SHALL cover, with ARGMAX_SIGNED_COMPARE_EN defined: inputs 0xBF800000 (-1.0), 0xC0000000 (-2.0), 0x7FC00000 (NaN), in_last on element 2 -> out_index=0, len_err=1.
